// File: rtl/text_scan_ctrl.sv
// Character-cell text scan controller: walks the raster, fetches text RAM cells and
// produces per-pixel glyph/attribute/sync/blank data two pix_en steps behind the counters.
module text_scan_ctrl #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter int unsigned COLS   = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_x,
    input  logic [4:0]  cursor_y,
    output logic [11:0] ram_addr,
    output logic        ram_en,
    input  logic [15:0] ram_data,
    output logic [7:0]  ascii,
    output logic [7:0]  attr,
    output logic [3:0]  row,
    output logic [2:0]  col,
    output logic        hsync,
    output logic        vsync,
    output logic        blank
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_W  = HW'(H_VIS);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_W  = VW'(V_VIS);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_VIS + V_FP + V_SYNC - 1);

    // Raster position and frame counters
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [4:0]    frame_q, frame_d;

    // Stage 1: position-derived flags
    logic [3:0] s1_row_q;
    logic [2:0] s1_col_q;
    logic       s1_vis_q, s1_hs_q, s1_vs_q, s1_hit_q;

    // Stage 2: output registers
    logic [7:0] ascii_q, attr_q, ascii_d, attr_d;
    logic [3:0] row_q;
    logic [2:0] col_q;
    logic       hsync_q, vsync_q, blank_q;

    logic        vis, in_hs, in_vs, hit;
    logic [11:0] cell_row, cell_col;

    always_comb begin
        h_d     = (h_q == H_LAST) ? '0 : h_q + 1'b1;
        v_d     = v_q;
        frame_d = frame_q;
        if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            if (v_q == V_LAST) begin
                frame_d = frame_q + 5'd1;
            end
        end
    end

    always_comb begin
        vis      = (h_q < H_VIS_W) && (v_q < V_VIS_W);
        in_hs    = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
        in_vs    = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
        cell_row = 12'(v_q >> 4);
        cell_col = 12'(h_q >> 3);
        ram_addr = vis ? 12'(cell_row * 12'(COLS) + cell_col) : 12'd0;
        // Gating with vis makes out-of-range cursor coordinates harmless
        hit      = cursor_en && frame_q[4] && vis
                   && (cell_col == {5'd0, cursor_x})
                   && (cell_row == {7'd0, cursor_y})
                   && (v_q[3:0] >= 4'd14);
    end

    always_comb begin
        ascii_d = 8'h00;
        attr_d  = 8'h00;
        if (s1_vis_q) begin
            ascii_d = ram_data[7:0];
            attr_d  = s1_hit_q ? {ram_data[15], ram_data[10:8], ram_data[11], ram_data[14:12]}
                               : ram_data[15:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q      <= '0;
            v_q      <= '0;
            frame_q  <= '0;
            s1_row_q <= '0;
            s1_col_q <= '0;
            s1_vis_q <= 1'b0;
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_hit_q <= 1'b0;
        end else if (pix_en) begin
            h_q      <= h_d;
            v_q      <= v_d;
            frame_q  <= frame_d;
            s1_row_q <= v_q[3:0];
            s1_col_q <= h_q[2:0];
            s1_vis_q <= vis;
            s1_hs_q  <= in_hs;
            s1_vs_q  <= in_vs;
            s1_hit_q <= hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ascii_q <= 8'h00;
            attr_q  <= 8'h00;
            row_q   <= '0;
            col_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b1;
        end else if (pix_en) begin
            ascii_q <= ascii_d;
            attr_q  <= attr_d;
            row_q   <= s1_row_q;
            col_q   <= s1_col_q;
            hsync_q <= ~s1_hs_q;
            vsync_q <= ~s1_vs_q;
            blank_q <= ~s1_vis_q;
        end
    end

    assign ram_en = pix_en;
    assign ascii  = ascii_q;
    assign attr   = attr_q;
    assign row    = row_q;
    assign col    = col_q;
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;
    assign blank  = blank_q;

endmodule

// File: tb/tb_text_scan_ctrl.sv
// Bench for text_scan_ctrl on a shrunken raster so many frames fit in a short run;
// a position/frame model predicts every output two enabled steps after its position.
module tb_text_scan_ctrl;

    localparam int H_VIS = 16, H_FP = 2, H_SYNC = 3, H_BP = 1;
    localparam int V_VIS = 32, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int COLS  = 80;
    localparam int H_T   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_T   = V_VIS + V_FP + V_SYNC + V_BP;
    // {ascii, attr, row, col, hsync, vsync, blank}
    localparam logic [25:0] RST_VEC = {8'h00, 8'h00, 4'h0, 3'h0, 1'b1, 1'b1, 1'b1};

    logic        clk = 1'b0;
    logic        rst, pix_en, cursor_en;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [11:0] ram_addr;
    logic        ram_en;
    logic [15:0] ram_data;
    logic [7:0]  ascii, attr;
    logic [3:0]  row;
    logic [2:0]  col;
    logic        hsync, vsync, blank;
    logic [25:0] obs;

    always #5 clk = ~clk;

    text_scan_ctrl #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .COLS(COLS)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .cursor_en(cursor_en),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .ram_addr(ram_addr), .ram_en(ram_en),
        .ram_data(ram_data), .ascii(ascii), .attr(attr), .row(row), .col(col),
        .hsync(hsync), .vsync(vsync), .blank(blank)
    );

    assign obs = {ascii, attr, row, col, hsync, vsync, blank};

    logic [15:0] mem [0:4095];
    int          mh, mv, mframe;
    logic [25:0] pend, out_exp;
    int          oh, ov, of, ph, pv, pf;
    bit          ovalid, pvalid;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [11:0] model_addr(input int h, input int v);
        if (h < H_VIS && v < V_VIS) return 12'((v / 16) * COLS + h / 8);
        return 12'd0;
    endfunction

    function automatic logic [25:0] model_out(input int h, input int v, input int f,
                                              input bit cen, input int cx, input int cy);
        logic [15:0] d;
        logic [7:0]  a, c;
        bit          vis, hs, vs;
        vis = (h < H_VIS) && (v < V_VIS);
        hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
        vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
        a   = 8'h00;
        c   = 8'h00;
        if (vis) begin
            d = mem[model_addr(h, v)];
            c = d[7:0];
            a = d[15:8];
            if (cen && (f % 32) >= 16 && h / 8 == cx && v / 16 == cy && v % 16 >= 14)
                a = (a & 8'h88) | ((a & 8'h07) << 4) | ((a >> 4) & 8'h07);
        end
        return {c, a, 4'(v % 16), 3'(h % 8), hs, vs, !vis};
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; mframe = 0;
        pend = RST_VEC; out_exp = RST_VEC;
        pvalid = 0; ovalid = 0;
    endtask

    task automatic step(input bit en);
        pix_en = en;
        @(posedge clk);
        #1;
        if (en) begin
            out_exp  = pend;
            pend     = model_out(mh, mv, mframe, cursor_en, int'(cursor_x), int'(cursor_y));
            ram_data = mem[model_addr(mh, mv)];
            oh = ph; ov = pv; of = pf; ovalid = pvalid;
            ph = mh; pv = mv; pf = mframe; pvalid = 1;
            if (mh == H_T - 1) begin
                mh = 0;
                if (mv == V_T - 1) begin
                    mv = 0;
                    mframe++;
                end else begin
                    mv++;
                end
            end else begin
                mh++;
            end
        end
    endtask

    task automatic seek(input int tx, input int ty);
        for (int i = 0; i < 4 * H_T * V_T && !(mh == tx && mv == ty); i++)
            step(1'($urandom_range(0, 3) != 0));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            pix_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (obs !== RST_VEC) begin
                errors++; $display("FAIL reset_outputs: got %h want %h", obs, RST_VEC);
            end
            checks++;
            if (ram_addr !== 12'd0) begin
                errors++; $display("FAIL reset_addr: got %0d want 0", ram_addr);
            end
            checks++;
            if (ram_en !== pix_en) begin
                errors++; $display("FAIL ram_en: got %b want %b", ram_en, pix_en);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            step(1'($urandom_range(0, 1)));
            checks++;
            if (obs !== out_exp) begin
                errors++; $display("FAIL startup_outputs: got %h want %h", obs, out_exp);
            end
            checks++;
            if (ram_addr !== model_addr(mh, mv)) begin
                errors++; $display("FAIL startup_addr: got %0d want %0d", ram_addr, model_addr(mh, mv));
            end
        end
    endtask

    task automatic test_reset_midline();
        seek(10, 20);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== RST_VEC || ram_addr !== 12'd0) begin
            errors++; $display("FAIL midline_reset: got %h/%0d want %h/0", obs, ram_addr, RST_VEC);
        end
        pix_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== RST_VEC || ram_addr !== 12'd0) begin
            errors++; $display("FAIL reset_hold: got %h/%0d want %h/0", obs, ram_addr, RST_VEC);
        end
        rst = 1'b0;
        model_reset();
        for (int n = 1; n <= 9; n++) begin
            step(1'b1);
            checks++;
            if (ram_addr !== ((n >= 8) ? 12'd1 : 12'd0)) begin
                errors++; $display("FAIL restart_count step %0d: addr %0d want %0d",
                                   n, ram_addr, (n >= 8) ? 1 : 0);
            end
            checks++;
            if (obs !== out_exp) begin
                errors++; $display("FAIL restart_outputs: got %h want %h", obs, out_exp);
            end
        end
    endtask

    task automatic test_fetch();
        cursor_en = 1'b0;
        seek(8, 16);
        pix_en = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (j < 8) begin
                checks++;
                if (ram_addr !== 12'd81) begin
                    errors++; $display("FAIL fetch_addr h=%0d: got %0d want 81", 8 + j, ram_addr);
                end
            end
            if (j >= 2) begin
                checks++;
                if ({ascii, attr, row, col, blank} !== {8'h41, 8'h1F, 4'd0, 3'(j - 2), 1'b0}) begin
                    errors++; $display("FAIL fetch_data col %0d: got %h %h %0d %0d %b", j - 2,
                                       ascii, attr, row, col, blank);
                end
            end
            step(1'b1);
        end
    endtask

    task automatic test_stall();
        seek(12, 5);
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 50; i++) begin
            step(1'b0);
            checks++;
            if (obs !== out_exp || ram_addr !== model_addr(mh, mv)) begin
                errors++; $display("FAIL stall_hold clk %0d: got %h/%0d want %h/%0d", i, obs,
                                   ram_addr, out_exp, model_addr(mh, mv));
            end
        end
        step(1'b1);
        checks++;
        if (obs !== out_exp || ram_addr !== model_addr(mh, mv)) begin
            errors++; $display("FAIL stall_resume: got %h/%0d want %h/%0d", obs, ram_addr,
                               out_exp, model_addr(mh, mv));
        end
    endtask

    task automatic test_timing();
        int   s = 0, hf = -1, vf = -1, nvf = 0, lin;
        logic phs, pvs;
        cursor_en = 1'b0;
        phs = hsync;
        pvs = vsync;
        while (nvf < 2 && s < 3 * H_T * V_T) begin
            step(1'b1);
            s++;
            checks++;
            if (obs !== out_exp) begin
                errors++; $display("FAIL timing_outputs: got %h want %h", obs, out_exp);
            end
            if (phs && !hsync) begin
                checks++;
                if ((mh - 2 + H_T) % H_T != H_VIS + H_FP) begin
                    errors++; $display("FAIL hsync_start: h %0d want %0d",
                                       (mh - 2 + H_T) % H_T, H_VIS + H_FP);
                end
                if (hf >= 0) begin
                    checks++;
                    if (s - hf != H_T) begin
                        errors++; $display("FAIL line_period: got %0d want %0d", s - hf, H_T);
                    end
                end
                hf = s;
            end
            if (!phs && hsync && hf >= 0) begin
                checks++;
                if (s - hf != H_SYNC) begin
                    errors++; $display("FAIL hsync_width: got %0d want %0d", s - hf, H_SYNC);
                end
            end
            if (pvs && !vsync) begin
                lin = (mv * H_T + mh - 2 + H_T * V_T) % (H_T * V_T);
                checks++;
                if (lin != (V_VIS + V_FP) * H_T) begin
                    errors++; $display("FAIL vsync_start: pos %0d want %0d", lin,
                                       (V_VIS + V_FP) * H_T);
                end
                if (vf >= 0) begin
                    checks++;
                    if (s - vf != V_T * H_T) begin
                        errors++; $display("FAIL frame_period: got %0d want %0d", s - vf, V_T * H_T);
                    end
                end
                vf = s;
                nvf++;
            end
            if (!pvs && vsync && vf >= 0) begin
                checks++;
                if (s - vf != V_SYNC * H_T) begin
                    errors++; $display("FAIL vsync_width: got %0d want %0d", s - vf, V_SYNC * H_T);
                end
            end
            phs = hsync;
            pvs = vsync;
            step(1'b0);
            checks++;
            if (obs !== out_exp || ram_addr !== model_addr(mh, mv)) begin
                errors++; $display("FAIL timing_idle_hold: got %h/%0d want %h/%0d", obs, ram_addr,
                                   out_exp, model_addr(mh, mv));
            end
        end
        checks++;
        if (nvf < 2) begin
            errors++; $display("FAIL timing_timeout: saw %0d vsync pulses want 2", nvf);
        end
    endtask

    task automatic test_cursor();
        int n = 0;
        while (mframe < 33 && n < 40000) begin
            if (mframe > 16 && mframe < 32) begin
                cursor_en = 1'($urandom_range(0, 3) != 0);
                cursor_x  = 7'($urandom_range(0, 3));
                cursor_y  = 5'($urandom_range(0, 2));
            end else begin
                cursor_en = 1'b1;
                cursor_x  = 7'd1;
                cursor_y  = 5'd1;
            end
            step(1'($urandom_range(0, 7) != 0));
            n++;
            checks++;
            if (obs !== out_exp || ram_addr !== model_addr(mh, mv)) begin
                errors++; $display("FAIL cursor_model: got %h/%0d want %h/%0d", obs, ram_addr,
                                   out_exp, model_addr(mh, mv));
            end
            if (ovalid && oh >= 8 && oh < 16 && (of == 16 || of == 32) && (ov == 29 || ov == 30))
            begin
                logic [7:0] want;
                want = (of == 16 && ov == 30) ? 8'h79 : 8'h1F;
                checks++;
                if (attr !== want) begin
                    errors++; $display("FAIL cursor_attr frame %0d v %0d h %0d: got %h want %h",
                                       of, ov, oh, attr, want);
                end
            end
        end
        checks++;
        if (mframe < 33) begin
            errors++; $display("FAIL cursor_timeout: reached frame %0d want 33", mframe);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] d0;
        d0 = mem[0];
        cursor_en = 1'b0;
        seek(H_T - 1, V_T - 1);
        step(1'b1);
        checks++;
        if (ram_addr !== 12'd0) begin
            errors++; $display("FAIL wrap_addr: got %0d want 0", ram_addr);
        end
        step(1'b1);
        step(1'b1);
        checks++;
        if ({ascii, row, col, blank, hsync, vsync} !== {d0[7:0], 4'd0, 3'd0, 1'b0, 1'b1, 1'b1})
        begin
            errors++; $display("FAIL wrap_origin: got %h %0d %0d %b want %h 0 0 0",
                               ascii, row, col, blank, d0[7:0]);
        end
        for (int i = 0; i < 8; i++) step(1'b1);
        checks++;
        if (ram_addr !== 12'd1 || obs !== out_exp) begin
            errors++; $display("FAIL wrap_continue: got %0d/%h want 1/%h", ram_addr, obs, out_exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        pix_en    = 1'b0;
        cursor_en = 1'b0;
        cursor_x  = 7'd0;
        cursor_y  = 5'd0;
        ram_data  = 16'h0000;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[81] = 16'h1F41;
        model_reset();
        ph = 0; pv = 0; pf = 0; oh = 0; ov = 0; of = 0;
        test_reset();
        test_reset_midline();
        test_fetch();
        test_stall();
        test_timing();
        test_cursor();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
